// File: rtl/coco_timer_if.sv
// rtl/coco_timer_if.sv - register bus and interrupt bundle for coco_timer
interface coco_timer_if;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  modport master (output Addr, We, DIn, input DOut, IRQ);
  modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/coco_timer.sv
// rtl/coco_timer.sv - 32-bit programmable down-counter timer with one-shot and auto-reload modes
module coco_timer #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input logic        Clk,
  input logic        Reset,
  coco_timer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;

  logic enable, auto_mode, ctrl_wr, preset_wr, expire, auto_exit;

  always_comb begin
    enable    = ctrl[0];
    auto_mode = (ctrl[2:1] == 2'b01);
    ctrl_wr   = bus.We && (bus.Addr == 2'd0);
    preset_wr = bus.We && (bus.Addr == 2'd1);
    expire    = (state == ST_CNT) && enable && (count == 32'd0);
    auto_exit = (state == ST_INT) && auto_mode;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      ctrl    <= 4'd0;
      preset  <= PRESET_RST;
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      // Software writes to CTRL override the FSM's one-shot clear of Enable.
      if (ctrl_wr)
        ctrl <= bus.DIn[3:0];
      else if (expire && !auto_mode)
        ctrl[0] <= 1'b0;

      if (preset_wr)
        preset <= bus.DIn;

      // Expiry sets pending even when it collides with an acknowledging write.
      if (expire)
        pending <= 1'b1;
      else if (auto_exit || ctrl_wr || preset_wr)
        pending <= 1'b0;

      case (state)
        ST_IDLE: if (enable) state <= ST_LOAD;
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!enable)
            state <= ST_IDLE;
          else if (count != 32'd0)
            count <= count - 32'd1;
          else
            state <= ST_INT;
        end
        ST_INT: state <= (auto_mode && enable) ? ST_LOAD : ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (bus.Addr)
      2'd0:    bus.DOut = {28'd0, ctrl};
      2'd1:    bus.DOut = preset;
      2'd2:    bus.DOut = count;
      default: bus.DOut = 32'd0;
    endcase
  end

  assign bus.IRQ = ctrl[3] & pending;

endmodule

// File: tb/tb_coco_timer.sv
// tb/tb_coco_timer.sv - self-checking bench for coco_timer
module tb_coco_timer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int passed = 0;
  int total = 0;

  coco_timer_if bus ();
  coco_timer #(.PRESET_RST(32'd0)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  chk_addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a; bus.We = 1'b1; bus.DIn = d;
    tick();
    bus.We = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOut;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
  endtask

  // Expected register read after plain register traffic with Enable kept low
  function automatic logic [31:0] reg_model(input logic [1:0] a, input logic [3:0] c, input logic [31:0] p);
    case (a)
      2'd0: return {28'd0, c};
      2'd1: return p;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    int held, n, k, found;
    logic [1:0] mode;
    logic [3:0] m_ctrl;
    logic [31:0] m_preset, d;
    logic [1:0] a, ra;
    logic exp_irq;
    logic [31:0] exp_cnt;
    int p;

    bus.Addr = 2'd0; bus.We = 1'b0; bus.DIn = 32'd0;

    vecs[0] = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
    vecs[2] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vecs[3] = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
    vecs[4] = '{1'b1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 2'd0, 32'hFFFFFFF6, 2'd0, 32'h6};
    vecs[6] = '{1'b1, 2'd2, 32'h12345678, 2'd2, 32'h0};
    vecs[7] = '{1'b1, 2'd3, 32'hDEADBEEF, 2'd3, 32'h0};
    vecs[8] = '{1'b1, 2'd1, 32'hA5A5A5A5, 2'd1, 32'hA5A5A5A5};
    vecs[9] = '{1'b1, 2'd0, 32'h0,        2'd0, 32'h0};

    do_reset();
    check("reset_irq", {31'd0, bus.IRQ}, 32'd0);
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
      else tick();
      rd(vecs[i].chk_addr, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // One-shot, PRESET=5
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (k = 1; k <= 8; k++) begin
      tick();
      if (k >= 2 && k <= 7) begin
        rd(2'd2, v);
        check($sformatf("os_count_e%0d", k), v, 32'(7 - k));
      end
      if (k == 7) check("os_irq_e7", {31'd0, bus.IRQ}, 32'd0);
    end
    check("os_irq_e8", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd0, v);
    check("os_ctrl_after", v, 32'h8);
    held = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.IRQ) held++;
    end
    check("os_irq_held", held, 32'd50);
    wr(2'd0, 32'h8);
    check("os_ack", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=3
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    held = 0;
    for (k = 1; k <= 30; k++) begin
      tick();
      if (bus.IRQ !== ((k % 6) == 0)) held++;
      if (k == 14) begin
        rd(2'd2, v);
        check("ar_reload", v, 32'd3);
      end
    end
    check("ar_pulse_pattern_errors", held, 32'd0);

    // Masked expiry still clears Enable
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.IRQ) held++;
    end
    check("mask_irq", held, 32'd0);
    rd(2'd0, v);
    check("mask_ctrl", v, 32'h0);
    wr(2'd0, 32'h8);
    check("mask_unmask_irq", {31'd0, bus.IRQ}, 32'd0);

    // Disable mid-count freezes COUNT; re-enable reloads
    do_reset();
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(2'd2, v);
      if (v == 32'd7) found = 1;
      else tick();
    end
    check("freeze_reach7", found, 32'd1);
    wr(2'd0, 32'h0);
    tick(); tick(); tick();
    rd(2'd2, v);
    check("freeze_count", v, 32'd6);
    wr(2'd0, 32'h1);
    tick(); tick();
    rd(2'd2, v);
    check("reenable_count", v, 32'd20);

    // Max PRESET
    do_reset();
    wr(2'd1, 32'hFFFFFFFF);
    wr(2'd0, 32'h1);
    tick(); tick();
    rd(2'd2, v);
    check("max_load", v, 32'hFFFFFFFF);
    tick();
    rd(2'd2, v);
    check("max_dec", v, 32'hFFFFFFFE);

    // PRESET=0 expires at edge 3
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(); tick();
    check("zero_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    tick();
    check("zero_irq_e3", {31'd0, bus.IRQ}, 32'd1);

    // PRESET write during CNT leaves current run alone
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(); tick();
    wr(2'd1, 32'd10);
    for (k = 4; k <= 8; k++) begin
      tick();
      if (k == 7) check("pw_irq_e7", {31'd0, bus.IRQ}, 32'd0);
    end
    check("pw_irq_e8", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd1, v);
    check("pw_preset", v, 32'd10);

    // CTRL write colliding with expiry
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(); tick(); tick(); tick();
    wr(2'd0, 32'hB);
    check("coll_irq", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd0, v);
    check("coll_ctrl", v, 32'hB);
    tick();
    check("coll_pulse_end", {31'd0, bus.IRQ}, 32'd0);

    // Asynchronous reset mid-run
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'hB);
    tick(); tick(); tick();
    #1 Reset = 1'b1;
    #1;
    check("arst_irq", {31'd0, bus.IRQ}, 32'd0);
    rd(2'd0, v);
    check("arst_ctrl", v, 32'd0);
    rd(2'd2, v);
    check("arst_count", v, 32'd0);
    tick();
    Reset = 1'b0;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd(2'd2, v);
      if (v != 32'd0 || bus.IRQ) held++;
    end
    check("arst_idle", held, 32'd0);

    // Random register traffic with Enable held low
    do_reset();
    m_ctrl = 4'd0; m_preset = 32'd0;
    for (int i = 0; i < 30; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd0) d[0] = 1'b0;
      wr(a, d);
      if (a == 2'd0) m_ctrl = d[3:0];
      if (a == 2'd1) m_preset = d;
      ra = 2'($urandom_range(0, 3));
      rd(ra, v);
      check($sformatf("rnd_reg_%0d_a%0d", i, ra), v, reg_model(ra, m_ctrl, m_preset));
    end

    // Random timed runs checked against closed-form schedule
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(0, 12);
      mode = 2'($urandom_range(0, 3));
      wr(2'd1, 32'(n));
      wr(2'd0, {28'd0, 1'b1, mode, 1'b1});
      held = 0;
      for (k = 1; k <= 3 * (n + 3) + 2; k++) begin
        tick();
        if (mode == 2'b01) begin
          exp_irq = (k >= n + 3) && (((k - (n + 3)) % (n + 3)) == 0);
          p = (k - 2) % (n + 3);
          exp_cnt = (k < 2) ? 32'd0 : (p <= n) ? 32'(n - p) : 32'd0;
        end else begin
          exp_irq = (k >= n + 3);
          exp_cnt = (k < 2 || k > n + 2) ? 32'd0 : 32'(n - (k - 2));
        end
        rd(2'd2, v);
        if (v !== exp_cnt || bus.IRQ !== exp_irq) begin
          held++;
          $display("FAIL rnd_run t%0d n=%0d mode=%0d k=%0d: count=%0d irq=%0b expected count=%0d irq=%0b",
                   t, n, mode, k, v, bus.IRQ, exp_cnt, exp_irq);
        end
      end
      total++;
      if (held == 0) passed++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
